// File: rtl/accumulator_sequencer_if.sv
// Control bundle between the accumulator sequencer and the 16-bit datapath.
// master = sequencer side, slave = datapath side.
interface accumulator_sequencer_if;
  logic        start;
  logic [15:0] ir;
  logic        acc_zero;
  logic        pc_inc;
  logic        pc_load;
  logic        mar_load;
  logic        mar_src;
  logic        mbr_load;
  logic        ir_load;
  logic        acc_load;
  logic [1:0]  acc_src;
  logic [3:0]  alu_op;
  logic        mem_we;
  logic        busy;
  logic        halted;
  logic        fault;
  logic [15:0] instr_count;

  modport master (
    input  start, ir, acc_zero,
    output pc_inc, pc_load, mar_load, mar_src, mbr_load, ir_load,
           acc_load, acc_src, alu_op, mem_we, busy, halted, fault, instr_count
  );

  modport slave (
    output start, ir, acc_zero,
    input  pc_inc, pc_load, mar_load, mar_src, mbr_load, ir_load,
           acc_load, acc_src, alu_op, mem_we, busy, halted, fault, instr_count
  );
endinterface

// File: rtl/accumulator_sequencer.sv
// Fetch/decode/execute controller for the 16-bit accumulator machine.
// Strobes are decoded combinationally from the registered state and IR.
//
// state   | meaning
// IDLE    | waiting for start after reset
// F0      | MAR <= PC
// F1      | memory read cycle for the instruction word
// F2      | IR <= memory, PC <= PC+1
// DEC     | decode opcode, count legal instructions
// E0..E3  | execute phases (operand address, read, MBR load, ACC load)
// HALTED  | HALT executed, start resumes at next instruction
// FAULT   | illegal opcode, sticky until reset
module accumulator_sequencer (
  input  logic                           clk,
  input  logic                           reset,
  accumulator_sequencer_if.master        bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_DEC, S_E0, S_E1, S_E2, S_E3, S_HALTED, S_FAULT
  } state_t;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_JUMP  = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_SHL   = 4'hA;
  localparam logic [3:0] OP_SHR   = 4'hB;
  localparam logic [3:0] OP_CLEAR = 4'hC;

  state_t      state, state_nxt;
  logic [3:0]  opcode;
  logic [15:0] instr_count;

  logic       pc_inc, pc_load, mar_load, mar_src, mbr_load, ir_load, acc_load, mem_we;
  logic [1:0] acc_src;
  logic [3:0] alu_op;

  assign opcode = bus.ir[15:12];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      instr_count <= 16'h0000;
    else if (state == S_DEC && opcode <= OP_CLEAR)
      instr_count <= instr_count + 16'd1;
  end

  always_comb begin
    state_nxt = state;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    mar_load  = 1'b0;
    mar_src   = 1'b0;
    mbr_load  = 1'b0;
    ir_load   = 1'b0;
    acc_load  = 1'b0;
    acc_src   = 2'b00;
    alu_op    = 4'b0000;
    mem_we    = 1'b0;
    case (state)
      S_IDLE, S_HALTED: begin
        if (bus.start) state_nxt = S_F0;
      end
      S_F0: begin
        mar_load  = 1'b1;
        state_nxt = S_F1;
      end
      S_F1: state_nxt = S_F2;
      S_F2: begin
        ir_load   = 1'b1;
        pc_inc    = 1'b1;
        state_nxt = S_DEC;
      end
      S_DEC: begin
        if (opcode == OP_HALT)      state_nxt = S_HALTED;
        else if (opcode > OP_CLEAR) state_nxt = S_FAULT;
        else                        state_nxt = S_E0;
      end
      S_E0: begin
        state_nxt = S_F0;
        case (opcode)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            mar_load  = 1'b1;
            mar_src   = 1'b1;
            state_nxt = S_E1;
          end
          OP_JUMP: pc_load = 1'b1;
          OP_JZ:   pc_load = bus.acc_zero;
          OP_SHL: begin
            acc_load = 1'b1;
            alu_op   = 4'b0100;
          end
          OP_SHR: begin
            acc_load = 1'b1;
            alu_op   = 4'b0101;
          end
          OP_CLEAR: begin
            acc_load = 1'b1;
            acc_src  = 2'b10;
          end
          default: ;
        endcase
      end
      S_E1: begin
        // STORE finishes here; the operand-fetch ops wait out the memory read
        if (opcode == OP_STORE) begin
          mem_we    = 1'b1;
          state_nxt = S_F0;
        end else begin
          state_nxt = S_E2;
        end
      end
      S_E2: begin
        mbr_load  = 1'b1;
        state_nxt = S_E3;
      end
      S_E3: begin
        acc_load  = 1'b1;
        state_nxt = S_F0;
        if (opcode == OP_LOAD) begin
          acc_src = 2'b01;
        end else begin
          case (opcode)
            OP_SUB:  alu_op = 4'b0001;
            OP_AND:  alu_op = 4'b1000;
            OP_OR:   alu_op = 4'b1001;
            OP_XOR:  alu_op = 4'b1010;
            default: alu_op = 4'b0000;
          endcase
        end
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.pc_inc      = pc_inc;
  assign bus.pc_load     = pc_load;
  assign bus.mar_load    = mar_load;
  assign bus.mar_src     = mar_src;
  assign bus.mbr_load    = mbr_load;
  assign bus.ir_load     = ir_load;
  assign bus.acc_load    = acc_load;
  assign bus.acc_src     = acc_src;
  assign bus.alu_op      = alu_op;
  assign bus.mem_we      = mem_we;
  assign bus.busy        = (state != S_IDLE) && (state != S_HALTED) && (state != S_FAULT);
  assign bus.halted      = (state == S_HALTED);
  assign bus.fault       = (state == S_FAULT);
  assign bus.instr_count = instr_count;

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Scoreboard bench for accumulator_sequencer: each issued instruction expands
// into its expected per-cycle strobe pattern; a monitor checks every busy cycle.
module tb_accumulator_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  accumulator_sequencer_if bus();

  accumulator_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [13:0] ctl;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] cnt_model = 16'h0000;
  int          cycle_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // {pc_inc, pc_load, mar_load, mar_src, mbr_load, ir_load, acc_load, acc_src, alu_op, mem_we}
  function automatic logic [13:0] mk(input bit pci, input bit pcl, input bit marl, input bit mars,
                                     input bit mbrl, input bit irl, input bit accl,
                                     input logic [1:0] accs, input logic [3:0] alu, input bit we);
    return {pci, pcl, marl, mars, mbrl, irl, accl, accs, alu, we};
  endfunction

  function automatic logic [13:0] dut_ctl();
    return {bus.pc_inc, bus.pc_load, bus.mar_load, bus.mar_src, bus.mbr_load, bus.ir_load,
            bus.acc_load, bus.acc_src, bus.alu_op, bus.mem_we};
  endfunction

  task automatic push(input logic [13:0] c);
    exp_t e;
    e.ctl = c;
    e.cnt = cnt_model;
    exp_q.push_back(e);
  endtask

  // Reference: the cycle-by-cycle behaviour an instruction must show.
  task automatic push_instr(input logic [15:0] instr, input bit az);
    logic [3:0] op;
    logic [3:0] alu;
    op = instr[15:12];
    push(mk(0,0,1,0,0,0,0,2'b00,4'h0,0));
    push(14'h0);
    push(mk(1,0,0,0,0,1,0,2'b00,4'h0,0));
    push(14'h0);
    if (op <= 4'hC) cnt_model = cnt_model + 16'd1;
    if (op == 4'h1 || (op >= 4'h3 && op <= 4'h7)) begin
      case (op)
        4'h4: alu = 4'b0001;
        4'h5: alu = 4'b1000;
        4'h6: alu = 4'b1001;
        4'h7: alu = 4'b1010;
        default: alu = 4'b0000;
      endcase
      push(mk(0,0,1,1,0,0,0,2'b00,4'h0,0));
      push(14'h0);
      push(mk(0,0,0,0,1,0,0,2'b00,4'h0,0));
      push(mk(0,0,0,0,0,0,1,(op == 4'h1) ? 2'b01 : 2'b00, alu, 0));
    end else if (op == 4'h2) begin
      push(mk(0,0,1,1,0,0,0,2'b00,4'h0,0));
      push(mk(0,0,0,0,0,0,0,2'b00,4'h0,1));
    end else if (op == 4'h8) push(mk(0,1,0,0,0,0,0,2'b00,4'h0,0));
    else if (op == 4'h9) push(mk(0,az,0,0,0,0,0,2'b00,4'h0,0));
    else if (op == 4'hA) push(mk(0,0,0,0,0,0,1,2'b00,4'b0100,0));
    else if (op == 4'hB) push(mk(0,0,0,0,0,0,1,2'b00,4'b0101,0));
    else if (op == 4'hC) push(mk(0,0,0,0,0,0,1,2'b10,4'h0,0));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.busy) begin
      cycle_idx++;
      if (exp_q.size() == 0) begin
        check("unexpected_busy_cycle", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("cycle%0d_ctl", cycle_idx), {18'd0, dut_ctl()}, {18'd0, e.ctl});
        check($sformatf("cycle%0d_count", cycle_idx), {16'd0, bus.instr_count}, {16'd0, e.cnt});
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_segment(input logic [15:0] prog[$], input bit azs[$]);
    bit done;
    foreach (prog[i]) push_instr(prog[i], azs[i]);
    pulse_start();
    foreach (prog[i]) begin
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
        @(negedge clk);
        if (bus.ir_load) done = 1'b1;
      end
      if (!done) begin
        check("ir_load_timeout", 32'd0, 32'd1);
        exp_q.delete();
        return;
      end
      bus.ir       = prog[i];
      bus.acc_zero = azs[i];
    end
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      #1;
      if (!bus.busy && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      check("segment_end_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  task automatic check_quiet(input string tag, input bit h, input bit f);
    check({tag, "_strobes"}, {18'd0, dut_ctl()}, 32'd0);
    check({tag, "_busy"},    {31'd0, bus.busy},   32'd0);
    check({tag, "_halted"},  {31'd0, bus.halted}, {31'd0, h});
    check({tag, "_fault"},   {31'd0, bus.fault},  {31'd0, f});
    check({tag, "_count"},   {16'd0, bus.instr_count}, {16'd0, cnt_model});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    cnt_model = 16'h0000;
    exp_q.delete();
    check_quiet("reset", 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic random_segment(input int len);
    logic [15:0] prog[$];
    bit          azs[$];
    for (int i = 0; i < len; i++) begin
      prog.push_back({4'($urandom_range(1, 12)), 12'($urandom)});
      azs.push_back(1'($urandom));
    end
    prog.push_back({4'h0, 12'($urandom)});
    azs.push_back(1'($urandom));
    run_segment(prog, azs);
    check_quiet("rand_halt", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prog[$];
    bit          azs[$];
    logic [15:0] cnt_snap;
    bit          hit;

    bus.start    = 1'b0;
    bus.ir       = 16'h0000;
    bus.acc_zero = 1'b0;
    #1 reset = 1'b1;
    #1;
    check_quiet("por", 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed program from the plan, ending in HALT
    prog = '{16'h1010, 16'h3005, 16'h4005, 16'h7005, 16'h2020, 16'h9040, 16'h9040, 16'h0000};
    azs  = '{0, 0, 0, 0, 0, 0, 1, 0};
    run_segment(prog, azs);
    check_quiet("halt", 1, 0);
    check("halt_count_value", {16'd0, bus.instr_count}, 32'd8);

    for (int s = 0; s < 3; s++) random_segment($urandom_range(8, 16));

    // Illegal opcode: fault is sticky, start ignored, count frozen
    cnt_snap = cnt_model;
    prog = '{16'hE000};
    azs  = '{0};
    run_segment(prog, azs);
    check_quiet("fault", 0, 1);
    pulse_start();
    repeat (4) @(negedge clk);
    check_quiet("fault_after_start", 0, 1);
    check("fault_count_frozen", {16'd0, bus.instr_count}, {16'd0, cnt_snap});

    do_reset();
    random_segment($urandom_range(10, 20));
    prog = '{{4'($urandom_range(13, 15)), 12'($urandom)}};
    azs  = '{0};
    run_segment(prog, azs);
    check_quiet("rand_fault", 0, 1);

    // Reset asserted during E1 of STORE drops mem_we without a clock edge
    do_reset();
    push_instr(16'h2020, 1'b0);
    pulse_start();
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      if (bus.ir_load) begin
        bus.ir = 16'h2020;
        bus.acc_zero = 1'b0;
      end
      if (bus.mem_we) hit = 1'b1;
    end
    check("store_mem_we_seen", {31'd0, hit}, 32'd1);
    #1 reset = 1'b1;
    #1;
    cnt_model = 16'h0000;
    check_quiet("mid_reset", 0, 0);
    check("mid_reset_queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_quiet("post_reset_idle", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
